// File: rtl/fetch_stage.sv
// Instruction fetch stage for the single-issue LEGv8 core.
// Owns the program counter and issues word reads over a req/ack handshake.
// Presents one instruction per cycle in the IF/ID register.
// A one-entry skid buffer absorbs the fetch that completes while decode stalls.
// A redirect squashes everything in flight; a request that cannot be aborted is drained.
module fetch_stage #(
    parameter int              N        = 64,
    parameter logic [N-1:0]    RESET_PC = '0
) (
    input  logic           clk,
    input  logic           reset,
    output logic           imem_req,
    output logic [N-1:0]   imem_addr,
    input  logic           imem_ack,
    input  logic [31:0]    imem_rdata,
    input  logic           stall,
    input  logic           redirect,
    input  logic [N-1:0]   redirect_pc,
    output logic           if_valid,
    output logic [31:0]    if_instr,
    output logic [N-1:0]   if_pc,
    output logic [10:0]    if_op
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [N-1:0]   r_pc;
    logic [N-1:0]   r_drain_addr;
    logic           r_skid_valid;
    logic [31:0]    r_skid_instr;
    logic [N-1:0]   r_skid_pc;
    logic           r_if_valid;
    logic [31:0]    r_if_instr;
    logic [N-1:0]   r_if_pc;

    logic           w_squash;
    logic           w_drain_capture;
    logic           w_load_ifid_mem;
    logic           w_load_ifid_skid;
    logic           w_load_skid;
    logic           w_bubble;
    logic           w_pc_inc;
    logic [N-1:0]   w_target;
    logic           w_unused;

    // Low two target bits are dropped so the PC always stays word aligned.
    assign w_target = {redirect_pc[N-1:2], 2'b00};
    assign w_unused = ^redirect_pc[1:0];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and datapath strobes; redirect outranks stall and ack.
    always_comb begin
        w_state_nxt      = r_state;
        w_squash         = 1'b0;
        w_drain_capture  = 1'b0;
        w_load_ifid_mem  = 1'b0;
        w_load_ifid_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_bubble         = 1'b0;
        w_pc_inc         = 1'b0;
        if (redirect) begin
            w_squash = 1'b1;
            case (r_state)
                S_REQ: begin
                    // An unacknowledged request cannot be withdrawn: drain it first.
                    w_state_nxt     = imem_ack ? S_REQ : S_DRAIN;
                    w_drain_capture = !imem_ack;
                end
                S_DRAIN: w_state_nxt = imem_ack ? S_REQ : S_DRAIN;
                default: w_state_nxt = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_ack) begin
                        w_pc_inc = 1'b1;
                        if (!stall || !r_if_valid) begin
                            w_load_ifid_mem = 1'b1;
                        end else begin
                            w_load_skid = 1'b1;
                            w_state_nxt = S_HOLD;
                        end
                    end else if (!stall && r_if_valid) begin
                        w_bubble = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_load_ifid_skid = 1'b1;
                        w_state_nxt      = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        w_state_nxt = S_REQ;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    // PC, skid buffer, IF/ID register and held drain address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_PC;
            r_drain_addr <= '0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_if_valid   <= 1'b0;
            r_if_instr   <= '0;
            r_if_pc      <= '0;
        end else begin
            if (w_drain_capture) begin
                r_drain_addr <= r_pc;
            end
            if (w_squash) begin
                r_pc         <= w_target;
                r_skid_valid <= 1'b0;
                r_skid_instr <= '0;
                r_skid_pc    <= '0;
                r_if_valid   <= 1'b0;
                r_if_instr   <= '0;
                r_if_pc      <= '0;
            end else begin
                if (w_pc_inc) begin
                    r_pc <= r_pc + N'(4);
                end
                if (w_load_ifid_mem) begin
                    r_if_valid <= 1'b1;
                    r_if_instr <= imem_rdata;
                    r_if_pc    <= r_pc;
                end
                if (w_load_skid) begin
                    r_skid_valid <= 1'b1;
                    r_skid_instr <= imem_rdata;
                    r_skid_pc    <= r_pc;
                end
                if (w_load_ifid_skid) begin
                    r_if_valid   <= r_skid_valid;
                    r_if_instr   <= r_skid_instr;
                    r_if_pc      <= r_skid_pc;
                    r_skid_valid <= 1'b0;
                    r_skid_instr <= '0;
                    r_skid_pc    <= '0;
                end
                if (w_bubble) begin
                    r_if_valid <= 1'b0;
                    r_if_instr <= '0;
                end
            end
        end
    end

    // Request is suppressed while reset is held so nothing is issued mid-reset.
    assign imem_req  = reset && (r_state != S_HOLD);
    assign imem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign if_op     = r_if_instr[31:21];

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the single-issue LEGv8 core; sits directly upstream of the main decoder. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and presents one instruction per cycle in an IF/ID register whose opcode field (instr[31:21]) drives the decoder's Op input. Handles decode-side stalls with a one-entry skid buffer and branch redirects with squash of in-flight fetches.

## Interface
- N, 64, PC and address width
- RESET_PC, 0, PC value loaded on reset (word aligned)

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  read request to instruction memory
- imem_addr  out  N  read address; stable while imem_req=1 and imem_ack=0
- imem_ack  in  1  read complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- stall  in  1  decode cannot accept a new instruction this cycle
- redirect  in  1  branch taken (PCSrc); squash and refetch
- redirect_pc  in  N  branch target; bits [1:0] ignored (treated as 0)
- if_valid  out  1  IF/ID register holds a real instruction
- if_instr  out  32  IF/ID instruction; 32'h0 when if_valid=0
- if_pc  out  N  address of if_instr
- if_op  out  11  if_instr[31:21]; 0 when invalid, so decoder emits all-zero controls

## Operation
- State register: REQ, DRAIN, HOLD. Plus PC (N bits), skid register (instr+pc+valid), IF/ID register.
- REQ: imem_req=1, imem_addr=PC. Ack may arrive same cycle as first request (zero-wait) or any later cycle.
  - ack and (stall=0 or if_valid=0): IF/ID <= {rdata, PC}, if_valid<=1, PC<=PC+4, stay REQ.
  - ack and stall=1 and if_valid=1: skid <= {rdata, PC}, PC<=PC+4, go HOLD.
  - no ack: hold PC/addr; if stall=0 and if_valid=1, if_valid<=0 (bubble).
- HOLD: imem_req=0. IF/ID and skid frozen while stall=1. When stall=0: IF/ID <= skid, skid cleared, go REQ.
- DRAIN: imem_req=1, imem_addr=address of abandoned request (held). On ack: discard rdata, go REQ at PC (already = redirect target).
- redirect=1 (priority over stall and ack, any state): PC <= {redirect_pc[N-1:2],2'b00}; if_valid<=0, if_instr<=0; skid cleared.
  - Next state: DRAIN if in REQ with imem_ack=0 (request cannot be aborted); otherwise REQ.
  - Redirect coincident with ack: data discarded, next cycle requests target.
- PC+4 wraps modulo 2^N; no exception.
- if_pc holds its last value when invalid is not required; it is cleared to 0 on squash.

## Timing
- Reset (asynchronous, immediate): PC=RESET_PC, state=REQ, imem_req=0 while reset low, if_valid=0, if_instr=0, if_op=0, if_pc=0, skid empty. Outstanding memory transaction abandoned.
- First cycle after reset release: imem_req=1, imem_addr=RESET_PC.
- Latency: instruction visible on if_instr the edge after its ack (1 cycle).
- Throughput: 1 instr/cycle with zero-wait memory and stall=0.
- Stall: if_* stable every cycle stall=1 and if_valid=1; no instruction lost or duplicated; at most one fetch completes during stall (into skid).
- Redirect: first target instruction on if_instr no earlier than 2 cycles after redirect cycle (zero-wait memory, no drain).
- imem_addr never changes while imem_req=1 and imem_ack=0.

## Test plan
- Reset release, zero-wait memory returning addr-encoded words: if_pc = 0,4,8,12 on consecutive cycles, if_valid=1 from cycle 2, if_op = rdata[31:21] (e.g. 0x7C2 for LDUR word 0xF8400000).
- Memory with 3-cycle ack latency: imem_addr held 3 cycles per request, if_valid pulses 1 cycle in 3, bubbles show if_instr=0, if_op=0.
- stall=1 for 4 cycles while valid at pc 8: if_pc stays 8, one request completes into skid (pc 12), imem_req=0 during HOLD; on release if_pc 12 then 16, no skip/duplicate.
- redirect to 0x100 coincident with ack, zero-wait: ack data dropped, if_valid=0 next cycle, then if_pc=0x100, 0x104; redirect_pc 0x103 yields 0x100.
- redirect while 4-cycle request outstanding at 0x20: DRAIN holds addr 0x20 until ack, data discarded, next request addr = target; redirect during stall+HOLD clears skid.
- PC=2^N-4 wrap and reset asserted mid-request: next PC 0; reset clears all outputs immediately without clock edge.
